// File: rtl/fifo_pkg.sv
// Shared types for the FIFO word packer: packer state encoding and count-width helper.
package fifo_pkg;

    typedef enum logic {PK_FILL, PK_HOLD} packer_state_t;

    function automatic int count_width(input int words);
        return $clog2(words + 1);
    endfunction

endpackage

// File: rtl/fifo_word_packer.sv
// Pops narrow FIFO entries and packs WORDS of them into one wide word, presented downstream
// with valid/ready; in_flush emits a partially filled word.
//
// state   | meaning
// PK_FILL | collecting entries into the fill registers
// PK_HOLD | packed word presented on out_data, waiting for in_ready
module fifo_word_packer
    import fifo_pkg::*;
#(
    parameter int DATA_BITS = 5,
    parameter int WORDS     = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    input  logic [DATA_BITS-1:0]          in_data,
    output logic                          out_read,
    input  logic                          in_flush,
    input  logic                          in_ready,
    output logic                          out_valid,
    output logic [DATA_BITS*WORDS-1:0]    out_data,
    output logic [$clog2(WORDS+1)-1:0]    out_count
);

    localparam int CW = count_width(WORDS);

    packer_state_t                        r_state, w_state_nxt;
    logic [CW-1:0]                        r_count, w_count_nxt;
    logic [CW-1:0]                        r_out_count, w_out_count_nxt;
    logic [WORDS-1:0][DATA_BITS-1:0]      r_fill, w_fill_nxt;
    logic [WORDS-1:0][DATA_BITS-1:0]      r_out, w_out_nxt;
    logic [WORDS-1:0][DATA_BITS-1:0]      w_fill_work;
    logic [CW-1:0]                        w_count_work;
    logic                                 w_pop;

    // out_read deliberately ignores in_valid so the FIFO sees a pure ready.
    assign out_read  = (r_state == PK_FILL) || ((r_state == PK_HOLD) && in_ready);
    assign w_pop     = in_valid && out_read;
    assign out_valid = (r_state == PK_HOLD);
    assign out_data  = r_out;
    assign out_count = r_out_count;

    always_comb begin
        w_state_nxt     = r_state;
        w_count_nxt     = r_count;
        w_out_count_nxt = r_out_count;
        w_fill_nxt      = r_fill;
        w_out_nxt       = r_out;
        w_fill_work     = r_fill;
        w_count_work    = r_count;

        case (r_state)
            PK_FILL: begin
                if (w_pop) begin
                    for (int i = 0; i < WORDS; i++) begin
                        if (CW'(i) == r_count) w_fill_work[i] = in_data;
                    end
                    w_count_work = r_count + CW'(1);
                end
                // Flush is evaluated after the same-cycle pop is included.
                if ((w_count_work == CW'(WORDS)) || (in_flush && (w_count_work != '0))) begin
                    w_state_nxt     = PK_HOLD;
                    w_out_nxt       = w_fill_work;
                    w_out_count_nxt = w_count_work;
                    w_fill_nxt      = '0;
                    w_count_nxt     = '0;
                end else begin
                    w_fill_nxt  = w_fill_work;
                    w_count_nxt = w_count_work;
                end
            end
            PK_HOLD: begin
                if (in_ready) begin
                    w_state_nxt     = PK_FILL;
                    w_out_nxt       = '0;
                    w_out_count_nxt = '0;
                    w_fill_nxt      = '0;
                    w_count_nxt     = '0;
                    if (w_pop) begin
                        w_fill_nxt[0] = in_data;
                        w_count_nxt   = CW'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= PK_FILL;
            r_count     <= '0;
            r_out_count <= '0;
            r_fill      <= '0;
            r_out       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_count     <= w_count_nxt;
            r_out_count <= w_out_count_nxt;
            r_fill      <= w_fill_nxt;
            r_out       <= w_out_nxt;
        end
    end

endmodule

// File: tb/tb_fifo_word_packer.sv
// Self-checking bench for fifo_word_packer: queue-based FIFO source, list-based packing model,
// per-cycle comparison plus literal checks on directed words.
module tb_fifo_word_packer;

    localparam int DB = 5;
    localparam int W  = 4;
    localparam int OW = DB * W;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [DB-1:0] in_data;
    logic          out_read;
    logic          in_flush;
    logic          in_ready;
    logic          out_valid;
    logic [OW-1:0] out_data;
    logic [CW-1:0] out_count;

    fifo_word_packer #(.DATA_BITS(DB), .WORDS(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_read  (out_read),
        .in_flush  (in_flush),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [DB-1:0]      src[$];        // FIFO contents, head at index 0
    bit                 m_hold;        // a word is being presented
    logic [DB-1:0]      m_fill[$];     // entries popped into the word under construction
    logic [OW-1:0]      m_data;
    int                 m_cnt;
    logic [OW+CW-1:0]   dut_words[$];  // {count, data} of every word the DUT handed over

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [OW-1:0] pack_fill();
        logic [OW-1:0] v = '0;
        foreach (m_fill[i]) v |= OW'(m_fill[i]) << (i * DB);
        return v;
    endfunction

    task automatic compare_outputs();
        chk("out_valid", 32'(out_valid), 32'(m_hold));
        chk("out_count", 32'(out_count), 32'(m_cnt));
        chk("out_data",  32'(out_data),  32'(m_data));
        chk("out_read",  32'(out_read),  32'(!m_hold || in_ready));
        if (out_valid && in_ready) dut_words.push_back({out_count, out_data});
    endtask

    // Called at a negedge; drives inputs, checks, advances the model across the next posedge.
    task automatic cycle(input bit gate, input bit rdy, input bit fl);
        bit            pop;
        logic [DB-1:0] d;
        in_valid = gate && (src.size() > 0);
        in_data  = in_valid ? src[0] : DB'($urandom);
        in_ready = rdy;
        in_flush = fl;
        #1;
        compare_outputs();
        pop = in_valid && (!m_hold || rdy);
        d   = in_data;
        if (pop) void'(src.pop_front());
        if (!m_hold) begin
            if (pop) m_fill.push_back(d);
            if (m_fill.size() == W || (fl && m_fill.size() > 0)) begin
                m_data = pack_fill();
                m_cnt  = m_fill.size();
                m_hold = 1'b1;
                m_fill.delete();
            end
        end else if (rdy) begin
            m_hold = 1'b0;
            m_data = '0;
            m_cnt  = 0;
            if (pop) m_fill.push_back(d);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        #2;
        reset = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_out_count", 32'(out_count), 32'd0);
        m_hold = 1'b0;
        m_data = '0;
        m_cnt  = 0;
        m_fill.delete();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic push(input int v);
        src.push_back(DB'(v));
    endtask

    int base;

    initial begin
        reset    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_flush = 1'b0;
        in_ready = 1'b0;
        m_hold   = 1'b0;
        m_data   = '0;
        m_cnt    = 0;
        #1;
        chk("init_out_valid", 32'(out_valid), 32'd0);
        chk("init_out_data",  32'(out_data),  32'd0);
        chk("init_out_count", 32'(out_count), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Tied-off FIFO: nothing happens
        repeat (4) cycle(1'b0, 1'b1, 1'b0);

        // Full word 0,3,6,9
        base = dut_words.size();
        push(0); push(3); push(6); push(9);
        repeat (6) cycle(1'b1, 1'b1, 1'b0);
        chk("t1_nwords", 32'(dut_words.size() - base), 32'd1);
        chk("t1_word", 32'(dut_words[base]), 32'({3'd4, 20'h49860}));

        // 32 entries streamed back to back
        base = dut_words.size();
        for (int i = 0; i < 32; i++) push((3 * i) & 31);
        repeat (40) cycle(1'b1, 1'b1, 1'b0);
        chk("t2_nwords", 32'(dut_words.size() - base), 32'd8);
        chk("t2_last_word", 32'(dut_words[base + 7]),
            32'({3'd4, 5'd29, 5'd26, 5'd23, 5'd20}));

        // Backpressure for 5 cycles with more entries waiting
        base = dut_words.size();
        for (int i = 0; i < 8; i++) push(i + 1);
        repeat (4) cycle(1'b1, 1'b1, 1'b0);
        repeat (5) cycle(1'b1, 1'b0, 1'b0);
        repeat (12) cycle(1'b1, 1'b1, 1'b0);
        chk("t3_nwords", 32'(dut_words.size() - base), 32'd2);
        chk("t3_word1", 32'(dut_words[base + 1]), 32'({3'd4, 5'd8, 5'd7, 5'd6, 5'd5}));

        // Flush with two lanes, then flushes with nothing pending
        base = dut_words.size();
        push(12); push(15);
        repeat (2) cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b1);
        cycle(1'b1, 1'b1, 1'b0);
        chk("t4_nwords", 32'(dut_words.size() - base), 32'd1);
        chk("t4_word", 32'(dut_words[base]), 32'({3'd2, 20'h001EC}));
        base = dut_words.size();
        repeat (3) cycle(1'b1, 1'b1, 1'b1);
        chk("t4_empty_flush", 32'(dut_words.size() - base), 32'd0);

        // Flush coincident with the pop of the third entry
        base = dut_words.size();
        push(12); push(15); push(2);
        repeat (2) cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b1);
        cycle(1'b1, 1'b1, 1'b0);
        chk("t5_word", 32'(dut_words[base]), 32'({3'd3, 20'h009EC}));

        // Flush coincident with a pop at count 0 gives a one-lane word
        base = dut_words.size();
        push(7);
        cycle(1'b1, 1'b1, 1'b1);
        cycle(1'b1, 1'b1, 1'b0);
        chk("t5_one_lane", 32'(dut_words[base]), 32'({3'd1, 20'h00007}));

        // Reset mid-word and while holding
        push(1); push(2);
        repeat (2) cycle(1'b1, 1'b1, 1'b0);
        do_reset();
        push(0); push(1); push(2); push(3);
        repeat (4) cycle(1'b1, 1'b0, 1'b0);
        do_reset();
        base = dut_words.size();
        push(10); push(11); push(12); push(13);
        repeat (6) cycle(1'b1, 1'b1, 1'b0);
        chk("t6_word", 32'(dut_words[base]), 32'({3'd4, 20'h6B16A}));

        // Randomized traffic
        repeat (400) begin
            if (src.size() < 8 && $urandom_range(1, 0) == 1) push(int'($urandom_range(31, 0)));
            cycle($urandom_range(3, 0) != 0, $urandom_range(2, 0) != 0, $urandom_range(7, 0) == 0);
        end
        repeat (30) cycle(1'b1, 1'b1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
